// File: rtl/patid_frame_sched_if.sv
// CLCT capture bundle plus shared-link handshake for the pattern-ID scheduler.
// The slave side is the scheduler. The master side is the CLCT finder together with the link arbiter.
interface patid_frame_sched_if #(
   parameter int BXN_W = 12
);
   logic             clct_strobe;
   logic             lct0_vpf;
   logic [2:0]       clct0_pid;
   logic             lct1_vpf;
   logic [2:0]       clct1_pid;
   logic [BXN_W-1:0] clct_bxn;
   logic             out_gnt;
   logic             out_req;
   logic             out_valid;
   logic [4:0]       out_pid;
   logic [BXN_W-1:0] out_bxn;

   modport master (
      output clct_strobe, lct0_vpf, clct0_pid, lct1_vpf, clct1_pid, clct_bxn, out_gnt,
      input  out_req, out_valid, out_pid, out_bxn
   );

   modport slave (
      input  clct_strobe, lct0_vpf, clct0_pid, lct1_vpf, clct1_pid, clct_bxn, out_gnt,
      output out_req, out_valid, out_pid, out_bxn
   );
endinterface

// File: rtl/patid_frame_sched.sv
// Per-BX scheduler: encodes the CLCT pair into a 5-bit pattern ID and queues it with its BXN.
// The queue is drained onto the shared link through a req/gnt handshake, one word every two cycles.
module patid_frame_sched #(
   parameter int DEPTH = 8,
   parameter int BXN_W = 12
) (
   input  logic                     clock,
   input  logic                     reset_n,
   patid_frame_sched_if.slave       lnk,
   input  logic                     skip_empty,
   input  logic                     ovf_clr,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [7:0]               ovf_cnt
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [4:0]       pid;
      logic [BXN_W-1:0] bxn;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, XMIT} state_t;

   state_t           state_q, state_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic [7:0]       ovf_q, ovf_d;
   logic [4:0]       pid_q, pid_d;
   logic [BXN_W-1:0] bxn_q, bxn_d;

   logic [4:0] enc;
   logic       push_req, push, pop, full, drop;

   always_comb begin
      enc = 5'd31;
      unique case ({lnk.lct0_vpf, lnk.lct1_vpf})
         2'b10:   enc = {2'b00, lnk.clct0_pid};
         2'b11:   enc = ({2'b00, lnk.clct1_pid} * 5'd5) + {2'b00, lnk.clct0_pid} + 5'd5;
         2'b01:   enc = 5'd30;
         default: enc = 5'd31;
      endcase
   end

   // The head is popped in the XMIT cycle, so a push into a full queue can reuse that slot.
   assign pop      = (state_q == XMIT);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign push_req = lnk.clct_strobe && !(skip_empty && enc == 5'd31);
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{pid: enc, bxn: lnk.clct_bxn};
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr)                   ovf_d = '0;
      else if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 1'b1;
   end

   // Output word is latched on the grant so it stays stable through XMIT and holds afterwards.
   always_comb begin
      state_d = state_q;
      pid_d   = pid_q;
      bxn_d   = bxn_q;
      unique case (state_q)
         IDLE: if (count_q != '0) state_d = REQ;
         REQ: begin
            if (lnk.out_gnt) begin
               state_d = XMIT;
               pid_d   = mem_q[rd_ptr_q].pid;
               bxn_d   = mem_q[rd_ptr_q].bxn;
            end
         end
         XMIT:    state_d = (count_d != '0) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= '0;
         pid_q    <= '0;
         bxn_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         pid_q    <= pid_d;
         bxn_q    <= bxn_d;
         mem_q    <= mem_d;
      end
   end

   assign lnk.out_req   = (state_q == REQ);
   assign lnk.out_valid = (state_q == XMIT);
   assign lnk.out_pid   = pid_q;
   assign lnk.out_bxn   = bxn_q;
   assign fifo_count    = count_q;
   assign ovf_cnt       = ovf_q;
endmodule
